fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 12, program counter and instruction address width.
REQ-002 clock  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ram_q  in  16  instruction word from the instruction RAM port, valid in the same cycle as ram_addr.
REQ-005 mem_wait  in  1  RAM not ready; high stalls the fetch.
REQ-006 sm_extra  in  1  decoder request for a second execute cycle.
REQ-007 stop  in  1  decoder halt request.
REQ-008 pc_sload  in  1  decoder jump strobe.
REQ-009 jump_addr  in  PC_W  jump target.
REQ-010 pc_cnt_en  in  1  decoder request to skip one word during execute.
REQ-011 ram_addr  out  PC_W  instruction fetch address; always equals pc.
REQ-012 pc  out  PC_W  program counter.
REQ-013 instruction  out  16  instruction register, fed to the decoder.
REQ-014 state  out  2  sequencer state, fed to the decoder.
REQ-015 halted  out  1  high while in HALT.
REQ-016 retired  out  16  count of completed instructions.

Function
REQ-017 State encoding SHALL be FETCH=00, EXEC1=10, EXEC2=01, HALT=11.
REQ-018 FETCH transitions:
- stop=1: go to HALT.
- stop=0, mem_wait=1: stay in FETCH; pc and instruction hold.
- stop=0, mem_wait=0: instruction<=ram_q, pc<=pc+1, go to EXEC1.
REQ-019 EXEC1 transitions:
- stop=1: go to HALT.
- else sm_extra=1: go to EXEC2.
- else: go to FETCH.
REQ-020 EXEC2 transitions:
- stop=1: go to HALT.
- else: go to FETCH.
- sm_extra is ignored in EXEC2.
REQ-021 HALT is terminal; only reset leaves HALT; pc, instruction and retired freeze in HALT.
REQ-022 In EXEC1 or EXEC2, pc_sload=1 loads pc<=jump_addr; otherwise pc_cnt_en=1 increments pc.
REQ-023 pc_sload SHALL take priority over pc_cnt_en when both are high.
REQ-024 pc_sload and pc_cnt_en SHALL be ignored in FETCH and HALT.
REQ-025 pc arithmetic SHALL be modulo 2^PC_W; all-ones plus 1 gives 0.
REQ-026 retired SHALL increment by 1 on each EXEC1->FETCH or EXEC2->FETCH transition, and never on a transition to HALT; it wraps 0xFFFF->0x0000.
REQ-027 Latency: instruction and state=EXEC1 are visible one cycle after a non-stalled FETCH; an instruction with sm_extra=0 occupies 2 cycles, and one with sm_extra=1 occupies 3 cycles.
REQ-028 stop SHALL take priority over mem_wait and sm_extra in every state.

Reset
REQ-029 On reset=1, asynchronously and without waiting for clock: state=FETCH, pc=0, instruction=0x0000, retired=0, halted=0.
REQ-030 Reset asserted mid-instruction or in HALT SHALL abort immediately, and the first edge after release SHALL perform a FETCH from address 0.

Structure
REQ-031 Shared package cpu_pkg SHALL hold the state encodings FETCH/EXEC1/EXEC2/HALT, PC_W default and the reset vector 0.
REQ-032 One sub-module program_counter SHALL be used: a PC_W-bit loadable up-counter with sload-over-count priority and asynchronous clear.
REQ-033 The sequencer FSM, instruction register and retired counter SHALL reside in fetch_sequencer.

Verification
REQ-034 Basic fetch/execute: release reset with ram_q=0x4010, mem_wait=0, sm_extra=0 -> next edge state=10, instruction=0x4010, pc=1; following edge state=00, retired=1.
REQ-035 Fetch stall: mem_wait=1 for 3 cycles in FETCH at pc=4 -> state=00, pc=4, instruction unchanged; after release -> state=10, pc=5.
REQ-036 Extra cycle and skip: sm_extra=1 in EXEC1 at pc=5 -> state=01; pc_cnt_en=1 in EXEC2 -> pc=6, then state=00, retired incremented once.
REQ-037 Jump priority: in EXEC1, pc_sload=1, pc_cnt_en=1, jump_addr=0x123 -> pc=0x123; the same strobes in FETCH -> no effect.
REQ-038 Halt and reset: stop=1 in EXEC1 at retired=7 -> state=11, halted=1, retired stays 7 over 10 cycles; reset mid-cycle -> state=00, pc=0 before the next edge.
REQ-039 Wrap-around: fetch at pc=0xFFF -> pc=0x000; retired=0xFFFF plus one completion -> 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared sequencer state encodings, PC width and reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_pc_w_default = 12;
    localparam int c_reset_vector = 0;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC1 = 2'b10,
        EXEC2 = 2'b01,
        HALT  = 2'b11
    } seq_state_t;

    function automatic logic is_exec(input seq_state_t s);
        return (s == EXEC1) || (s == EXEC2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Loadable modulo-2^PC_W up-counter, load wins over count.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import cpu_pkg::*;
#(
    parameter int PC_W = c_pc_w_default
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sload,
    input  logic            cnt_en,
    input  logic [PC_W-1:0] data,
    output logic [PC_W-1:0] q
);

    logic [PC_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= PC_W'(c_reset_vector);
        end else if (sload) begin
            r_count <= data;
        end else if (cnt_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign q = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch/execute sequencer with instruction register, PC and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = c_pc_w_default
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     ram_q,
    input  logic            mem_wait,
    input  logic            sm_extra,
    input  logic            stop,
    input  logic            pc_sload,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            pc_cnt_en,
    output logic [PC_W-1:0] ram_addr,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     instruction,
    output logic [1:0]      state,
    output logic            halted,
    output logic [15:0]     retired
);

    seq_state_t      r_state;
    seq_state_t      w_next_state;
    logic [15:0]     r_instruction;
    logic [15:0]     r_retired;
    logic            w_ir_load;
    logic            w_retire;
    logic            w_in_exec;
    logic            w_pc_sload;
    logic            w_pc_cnt;
    logic [PC_W-1:0] w_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // stop outranks every other condition in every state
    always_comb begin
        w_next_state = r_state;
        w_ir_load    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FETCH: begin
                if (stop) begin
                    w_next_state = HALT;
                end else if (!mem_wait) begin
                    w_ir_load    = 1'b1;
                    w_next_state = EXEC1;
                end
            end
            EXEC1: begin
                if (stop) begin
                    w_next_state = HALT;
                end else if (sm_extra) begin
                    w_next_state = EXEC2;
                end else begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                end
            end
            EXEC2: begin
                if (stop) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    assign w_in_exec  = is_exec(r_state);
    assign w_pc_sload = w_in_exec & pc_sload;
    assign w_pc_cnt   = w_ir_load | (w_in_exec & pc_cnt_en);

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clock  (clock),
        .reset  (reset),
        .sload  (w_pc_sload),
        .cnt_en (w_pc_cnt),
        .data   (jump_addr),
        .q      (w_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instruction <= 16'h0000;
            r_retired     <= 16'h0000;
        end else begin
            if (w_ir_load) begin
                r_instruction <= ram_q;
            end
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign pc          = w_pc;
    assign ram_addr    = w_pc;
    assign instruction = r_instruction;
    assign state       = r_state;
    assign halted      = (r_state == HALT);
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed plus randomized bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W = 12;

    logic            clock = 1'b0;
    logic            reset;
    logic [15:0]     ram_q;
    logic            mem_wait;
    logic            sm_extra;
    logic            stop;
    logic            pc_sload;
    logic [PC_W-1:0] jump_addr;
    logic            pc_cnt_en;
    logic [PC_W-1:0] ram_addr;
    logic [PC_W-1:0] pc;
    logic [15:0]     instruction;
    logic [1:0]      state;
    logic            halted;
    logic [15:0]     retired;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum {P_FETCH, P_EX1, P_EX2, P_HALT} phase_t;
    phase_t      m_phase;
    int          m_pc;
    logic [15:0] m_ir;
    int          m_ret;

    fetch_sequencer #(.PC_W(PC_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .ram_q       (ram_q),
        .mem_wait    (mem_wait),
        .sm_extra    (sm_extra),
        .stop        (stop),
        .pc_sload    (pc_sload),
        .jump_addr   (jump_addr),
        .pc_cnt_en   (pc_cnt_en),
        .ram_addr    (ram_addr),
        .pc          (pc),
        .instruction (instruction),
        .state       (state),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] phase_code(input phase_t p);
        case (p)
            P_FETCH: return 2'b00;
            P_EX1:   return 2'b10;
            P_EX2:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state",       32'(state),       32'(phase_code(m_phase)));
        check("pc",          32'(pc),          32'(m_pc));
        check("ram_addr",    32'(ram_addr),    32'(m_pc));
        check("instruction", 32'(instruction), 32'(m_ir));
        check("retired",     32'(retired),     32'(m_ret));
        check("halted",      32'(halted),      32'(m_phase == P_HALT));
    endtask

    task automatic model_reset();
        m_phase = P_FETCH;
        m_pc    = 0;
        m_ir    = 16'h0000;
        m_ret   = 0;
    endtask

    // Behavioural rules: one call per rising edge with the inputs seen at it
    task automatic model_step(input logic [15:0] q, input logic w, input logic e,
                              input logic s, input logic sl, input int ja, input logic ce);
        if (m_phase == P_HALT) return;
        if (m_phase == P_EX1 || m_phase == P_EX2) begin
            if (sl)      m_pc = ja;
            else if (ce) m_pc = (m_pc + 1) % (1 << PC_W);
        end
        if (s) begin
            m_phase = P_HALT;
        end else if (m_phase == P_FETCH) begin
            if (!w) begin
                m_ir    = q;
                m_pc    = (m_pc + 1) % (1 << PC_W);
                m_phase = P_EX1;
            end
        end else if (m_phase == P_EX1 && e) begin
            m_phase = P_EX2;
        end else begin
            m_phase = P_FETCH;
            m_ret   = (m_ret + 1) % 65536;
        end
    endtask

    task automatic tick(input logic [15:0] q, input logic w, input logic e, input logic s,
                        input logic sl, input logic [PC_W-1:0] ja, input logic ce);
        ram_q = q; mem_wait = w; sm_extra = e; stop = s;
        pc_sload = sl; jump_addr = ja; pc_cnt_en = ce;
        @(posedge clock);
        model_step(q, w, e, s, sl, int'(ja), ce);
        #1;
        check_all();
    endtask

    // Asserted between edges; outputs must clear before any clock arrives
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ram_q = '0; mem_wait = 1'b0; sm_extra = 1'b0; stop = 1'b0;
        pc_sload = 1'b0; jump_addr = '0; pc_cnt_en = 1'b0;
        model_reset();
        #3;
        check_all();
        @(posedge clock); #1;
        reset = 1'b0;

        // basic fetch/execute
        tick(16'h4010, 0, 0, 0, 0, 12'h000, 0);
        check("basic_ir", 32'(instruction), 32'h4010);
        tick(16'h1111, 0, 0, 0, 0, 12'h000, 0);
        check("basic_retired", 32'(retired), 32'd1);

        // advance to FETCH at pc=4
        for (int i = 0; i < 3; i++) begin
            tick(16'h2000 + 16'(i), 0, 0, 0, 0, 12'h000, 0);
            tick(16'h0000, 0, 0, 0, 0, 12'h000, 0);
        end
        check("pc_at_stall", 32'(pc), 32'd4);

        // fetch stall, then extra cycle with skip
        for (int i = 0; i < 3; i++) tick(16'hBEEF, 1, 0, 0, 0, 12'h000, 0);
        tick(16'h5A5A, 0, 0, 0, 0, 12'h000, 0);
        tick(16'h0000, 0, 1, 0, 0, 12'h000, 0);
        tick(16'h0000, 0, 1, 0, 0, 12'h000, 1);
        check("skip_pc", 32'(pc), 32'd6);

        // jump priority in EXEC1, strobes ignored in FETCH
        tick(16'h3333, 0, 0, 0, 0, 12'h000, 0);
        tick(16'h0000, 0, 0, 0, 1, 12'h123, 1);
        check("jump_pc", 32'(pc), 32'h123);
        tick(16'h0000, 1, 0, 0, 1, 12'h456, 1);
        tick(16'h7777, 0, 0, 0, 1, 12'h456, 1);

        // pc wrap: jump to 0xFFF, then fetch there
        tick(16'h0000, 0, 0, 0, 1, 12'hFFF, 0);
        tick(16'h8888, 0, 0, 0, 0, 12'h000, 0);
        check("pc_wrap", 32'(pc), 32'h000);
        tick(16'h0000, 0, 0, 0, 0, 12'h000, 0);

        // retired wrap: preload all-ones then complete one instruction
        force dut.r_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFF;
        tick(16'h9999, 0, 0, 0, 0, 12'h000, 0);
        tick(16'h0000, 0, 0, 0, 0, 12'h000, 0);
        check("retired_wrap", 32'(retired), 32'h0000);

        // reach retired=7, halt from EXEC1, stay frozen
        for (int i = 0; i < 7; i++) begin
            tick(16'h1000 + 16'(i), 0, 0, 0, 0, 12'h000, 0);
            tick(16'h0000, 0, 0, 0, 0, 12'h000, 0);
        end
        tick(16'hCAFE, 0, 0, 0, 0, 12'h000, 0);
        tick(16'h0000, 0, 1, 1, 0, 12'h000, 0);
        check("halt_state", 32'(state), 32'h3);
        for (int i = 0; i < 10; i++)
            tick(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 12'($urandom), 1'($urandom));
        check("halt_retired", 32'(retired), 32'd7);

        pulse_reset();
        tick(16'hABCD, 0, 0, 0, 0, 12'h000, 0);
        check("post_reset_pc", 32'(pc), 32'd1);

        // reset mid-instruction
        tick(16'h0000, 0, 1, 0, 0, 12'h000, 0);
        pulse_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic s, sl, ce;
            s  = ($urandom_range(0, 39) == 0);
            sl = ($urandom_range(0, 3) == 0) && !s;
            ce = 1'($urandom) && !s;
            tick(16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), s,
                 sl, 12'($urandom), ce);
            if ((m_phase == P_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0)
                pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
